mempool_host_ctrl: RTL and testbench

MEMPOOL_HOST_CTRL -- requirements
Module: mempool_host_ctrl

---
 rtl/mempool_host_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mempool_host_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mempool_host_ctrl.sv
// mempool_host_ctrl: host-side boot/run sequencer for a MemPool cluster.
// It waits BootWaitCycles after start, writes all-ones to the wake-up register,
// then either waits for eoc_valid_i or polls the EOC register. When the
// computation has finished, it reads the EOC register, reports retval_o and
// sets done_o.
// Ports:
//   clk_i, rst_i (async, active-high)     clock / reset
//   start_i                               start pulse (accepted in IDLE/DONE)
//   eoc_valid_i                           end-of-computation level
//   aw_*/w_*/b_*                          AXI write channels (single-beat)
//   ar_*/r_*                              AXI read channels (single-beat)
//   done_o, error_o, retval_o             run status (sticky until next start)
module mempool_host_ctrl #(
    parameter logic [31:0] CtrlBaseAddr   = 32'h4000_0000,
    parameter int unsigned BootWaitCycles = 1000,
    parameter bit          PollEoc        = 1'b0,
    parameter int unsigned PollInterval   = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        eoc_valid_i,
    output logic        aw_valid_o,
    input  logic        aw_ready_i,
    output logic [31:0] aw_addr_o,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    output logic [31:0] w_data_o,
    output logic [3:0]  w_strb_o,
    input  logic        b_valid_i,
    output logic        b_ready_o,
    input  logic [1:0]  b_resp_i,
    output logic        ar_valid_o,
    input  logic        ar_ready_i,
    output logic [31:0] ar_addr_o,
    input  logic        r_valid_i,
    output logic        r_ready_o,
    input  logic [31:0] r_data_i,
    input  logic [1:0]  r_resp_i,
    output logic        done_o,
    output logic        error_o,
    output logic [30:0] retval_o
);

    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned StrbW = 4;
    localparam int unsigned CntW  = 32;
    localparam int unsigned RetW  = 31;

    localparam logic [AddrW-1:0] EocAddr  = CtrlBaseAddr;
    localparam logic [AddrW-1:0] WakeAddr = CtrlBaseAddr + AddrW'(4);
    localparam logic [DataW-1:0] WakeData = {DataW{1'b1}};
    localparam logic [StrbW-1:0] WakeStrb = {StrbW{1'b1}};

    typedef enum logic [3:0] {
        IDLE,
        BOOT,
        WR_AW,
        WR_W,
        WR_B,
        WAIT_EOC,
        POLL_WAIT,
        RD_AR,
        RD_R,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              aw_valid_q, aw_valid_d;
    logic [AddrW-1:0]  aw_addr_q, aw_addr_d;
    logic              w_valid_q, w_valid_d;
    logic [DataW-1:0]  w_data_q, w_data_d;
    logic [StrbW-1:0]  w_strb_q, w_strb_d;
    logic              b_ready_q, b_ready_d;
    logic              ar_valid_q, ar_valid_d;
    logic [AddrW-1:0]  ar_addr_q, ar_addr_d;
    logic              r_ready_q, r_ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [RetW-1:0]   retval_q, retval_d;

    // Next-state, counter and status logic; bus outputs are decoded from the
    // next state so they are registered yet aligned with the state they belong to.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);
        error_d  = error_q;
        retval_d = retval_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    error_d  = 1'b0;
                    retval_d = '0;
                    cnt_d    = CntW'(BootWaitCycles);
                    state_d  = BOOT;
                end
            end
            BOOT: begin
                if (cnt_q == '0) state_d = WR_AW;
            end
            WR_AW: begin
                if (aw_ready_i) state_d = WR_W;
            end
            WR_W: begin
                if (w_ready_i) state_d = WR_B;
            end
            WR_B: begin
                if (b_valid_i) begin
                    if (b_resp_i != 2'b00) error_d = 1'b1;
                    if (PollEoc) begin
                        cnt_d   = CntW'(PollInterval);
                        state_d = POLL_WAIT;
                    end else begin
                        state_d = WAIT_EOC;
                    end
                end
            end
            WAIT_EOC: begin
                if (eoc_valid_i) state_d = RD_AR;
            end
            POLL_WAIT: begin
                if (cnt_q == '0) state_d = RD_AR;
            end
            RD_AR: begin
                if (ar_ready_i) state_d = RD_R;
            end
            RD_R: begin
                if (r_valid_i) begin
                    if (r_resp_i != 2'b00) error_d = 1'b1;
                    // A zero EOC word while polling means the cluster is still running.
                    if (PollEoc && (r_data_i == '0)) begin
                        cnt_d   = CntW'(PollInterval);
                        state_d = POLL_WAIT;
                    end else begin
                        retval_d = r_data_i[DataW-1:1];
                        state_d  = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        aw_valid_d = (state_d == WR_AW);
        aw_addr_d  = aw_valid_d ? WakeAddr : '0;
        w_valid_d  = (state_d == WR_W);
        w_data_d   = w_valid_d ? WakeData : '0;
        w_strb_d   = w_valid_d ? WakeStrb : '0;
        b_ready_d  = (state_d == WR_B);
        ar_valid_d = (state_d == RD_AR);
        ar_addr_d  = ar_valid_d ? EocAddr : '0;
        r_ready_d  = (state_d == RD_R);
        done_d     = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            r_ready_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            retval_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            r_ready_q  <= r_ready_d;
            done_q     <= done_d;
            error_q    <= error_d;
            retval_q   <= retval_d;
        end
    end

    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = aw_addr_q;
    assign w_valid_o  = w_valid_q;
    assign w_data_o   = w_data_q;
    assign w_strb_o   = w_strb_q;
    assign b_ready_o  = b_ready_q;
    assign ar_valid_o = ar_valid_q;
    assign ar_addr_o  = ar_addr_q;
    assign r_ready_o  = r_ready_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign retval_o   = retval_q;

endmodule

// File: tb/tb_mempool_host_ctrl.sv
// Testbench for mempool_host_ctrl: one instance waits for eoc_valid_i, the
// other polls the EOC register; both share stimulus, sel picks the observed one.
module tb_mempool_host_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        eoc = 1'b0;
    logic        aw_ready = 1'b1;
    logic        w_ready = 1'b1;
    logic        b_valid = 1'b1;
    logic [1:0]  b_resp = 2'b00;
    logic        ar_ready = 1'b1;
    logic        r_valid = 1'b1;
    logic [31:0] r_data = '0;
    logic [1:0]  r_resp = 2'b00;
    bit          sel = 1'b0;

    logic        aw_valid0, aw_valid1, w_valid0, w_valid1, b_ready0, b_ready1;
    logic        ar_valid0, ar_valid1, r_ready0, r_ready1;
    logic        done0, done1, error0, error1;
    logic [31:0] aw_addr0, aw_addr1, w_data0, w_data1, ar_addr0, ar_addr1;
    logic [3:0]  w_strb0, w_strb1;
    logic [30:0] retval0, retval1;

    always #5 clk = ~clk;

    mempool_host_ctrl #(
        .CtrlBaseAddr(32'h4000_0000), .BootWaitCycles(4), .PollEoc(1'b0), .PollInterval(3)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .eoc_valid_i(eoc),
        .aw_valid_o(aw_valid0), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr0),
        .w_valid_o(w_valid0), .w_ready_i(w_ready), .w_data_o(w_data0), .w_strb_o(w_strb0),
        .b_valid_i(b_valid), .b_ready_o(b_ready0), .b_resp_i(b_resp),
        .ar_valid_o(ar_valid0), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr0),
        .r_valid_i(r_valid), .r_ready_o(r_ready0), .r_data_i(r_data), .r_resp_i(r_resp),
        .done_o(done0), .error_o(error0), .retval_o(retval0)
    );

    mempool_host_ctrl #(
        .CtrlBaseAddr(32'h4000_0000), .BootWaitCycles(4), .PollEoc(1'b1), .PollInterval(3)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .eoc_valid_i(eoc),
        .aw_valid_o(aw_valid1), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr1),
        .w_valid_o(w_valid1), .w_ready_i(w_ready), .w_data_o(w_data1), .w_strb_o(w_strb1),
        .b_valid_i(b_valid), .b_ready_o(b_ready1), .b_resp_i(b_resp),
        .ar_valid_o(ar_valid1), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr1),
        .r_valid_i(r_valid), .r_ready_o(r_ready1), .r_data_i(r_data), .r_resp_i(r_resp),
        .done_o(done1), .error_o(error1), .retval_o(retval1)
    );

    logic        s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready, s_done, s_error;
    logic [31:0] s_aw_addr, s_w_data, s_ar_addr;
    logic [3:0]  s_w_strb;
    logic [30:0] s_retval;

    assign s_aw_valid = sel ? aw_valid1 : aw_valid0;
    assign s_aw_addr  = sel ? aw_addr1  : aw_addr0;
    assign s_w_valid  = sel ? w_valid1  : w_valid0;
    assign s_w_data   = sel ? w_data1   : w_data0;
    assign s_w_strb   = sel ? w_strb1   : w_strb0;
    assign s_b_ready  = sel ? b_ready1  : b_ready0;
    assign s_ar_valid = sel ? ar_valid1 : ar_valid0;
    assign s_ar_addr  = sel ? ar_addr1  : ar_addr0;
    assign s_r_ready  = sel ? r_ready1  : r_ready0;
    assign s_done     = sel ? done1     : done0;
    assign s_error    = sel ? error1    : error0;
    assign s_retval   = sel ? retval1   : retval0;

    typedef struct {
        bit          sel;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        int          eoc_dly;
        logic [30:0] exp_ret;
        logic        exp_err;
        int          exp_ar;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Runs one full boot/run sequence with a simple always-ready slave; the
    // k-th read returns dk. Returns the AR handshake count and whether DONE was reached.
    task automatic run_seq(input vec_t v, input bit do_reset, output int n_ar, output bit fin);
        logic [31:0] rd [3];
        int since_b;
        rd[0] = v.d0; rd[1] = v.d1; rd[2] = v.d2;
        n_ar = 0; since_b = -1; fin = 1'b0;
        sel = v.sel; b_resp = v.bresp; r_resp = v.rresp; r_data = v.d0; eoc = 1'b0;
        aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1; b_valid = 1'b1; r_valid = 1'b1;
        if (do_reset) begin
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
        end
        pulse_start();
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (s_ar_valid && ar_ready) begin
                n_ar++;
                if (n_ar <= 3) r_data = rd[n_ar-1];
            end
            if (s_b_ready && b_valid) since_b = 0;
            else if (since_b >= 0) since_b++;
            eoc = (since_b >= 0) && (since_b >= v.eoc_dly);
            if (s_done) fin = 1'b1;
            else @(negedge clk);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int  n_ar;
        bit  fin;
        bit  seen;
        vec_t v;

        vecs[0] = '{1'b0, 2'b00, 2'b00, 32'h0000_0055, 32'h0, 32'h0, 50, 31'h0000_002A, 1'b0, 1};
        vecs[1] = '{1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0000_0003, 0, 31'h0000_0001, 1'b0, 3};
        vecs[2] = '{1'b0, 2'b10, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0, 5, 31'h7FFF_FFFF, 1'b1, 1};
        vecs[3] = '{1'b1, 2'b00, 2'b10, 32'h8000_0000, 32'h0, 32'h0, 0, 31'h4000_0000, 1'b1, 1};
        vecs[4] = '{1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 0, 31'h0, 1'b0, 1};
        vecs[5] = '{1'b1, 2'b00, 2'b00, 32'h0000_0001, 32'h0, 32'h0, 0, 31'h0, 1'b0, 1};

        // Reset values.
        sel = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_valids", 32'({s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready}), 32'd0);
        chk("rst_status", 32'({s_done, s_error}), 32'd0);
        chk("rst_retval", 32'(s_retval), 32'd0);
        chk("rst_aw_addr", s_aw_addr, 32'd0);
        chk("rst_w_data", s_w_data, 32'd0);
        chk("rst_ar_addr", s_ar_addr, 32'd0);
        rst = 1'b0;

        // Boot delay of 4: aw_valid appears 5 cycles after start, then stalls on aw_ready.
        aw_ready = 1'b0; w_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("boot_aw_valid_c%0d", k), 32'(s_aw_valid), (k == 5) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall_aw_valid_%0d", i), 32'(s_aw_valid), 32'd1);
            chk($sformatf("stall_aw_addr_%0d", i), s_aw_addr, 32'h4000_0004);
            chk($sformatf("stall_w_valid_%0d", i), 32'(s_w_valid), 32'd0);
            if (i < 9) @(negedge clk);
        end
        aw_ready = 1'b1;
        @(negedge clk);
        chk("w_phase_aw_valid", 32'(s_aw_valid), 32'd0);
        chk("w_phase_w_valid", 32'(s_w_valid), 32'd1);
        chk("w_phase_w_data", s_w_data, 32'hFFFF_FFFF);
        chk("w_phase_w_strb", 32'(s_w_strb), 32'hF);

        // Table of complete runs.
        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i], 1'b1, n_ar, fin);
            chk($sformatf("v%0d_reached_done", i), 32'(fin), 32'd1);
            chk($sformatf("v%0d_done", i), 32'(s_done), 32'd1);
            chk($sformatf("v%0d_error", i), 32'(s_error), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_retval", i), 32'(s_retval), 32'(vecs[i].exp_ret));
            chk($sformatf("v%0d_ar_count", i), 32'(n_ar), 32'(vecs[i].exp_ar));
        end

        // Sticky error survives DONE and is cleared by the next start.
        v = vecs[0];
        v.bresp = 2'b10; v.eoc_dly = 3;
        run_seq(v, 1'b1, n_ar, fin);
        repeat (3) @(negedge clk);
        chk("sticky_done", 32'(s_done), 32'd1);
        chk("sticky_error", 32'(s_error), 32'd1);
        chk("sticky_retval", 32'(s_retval), 32'h2A);
        pulse_start();
        chk("restart_done_clr", 32'(s_done), 32'd0);
        chk("restart_error_clr", 32'(s_error), 32'd0);
        chk("restart_retval_clr", 32'(s_retval), 32'd0);

        // Reset while waiting in the read-data phase, then a full replay.
        sel = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        b_resp = 2'b10; r_valid = 1'b0; eoc = 1'b1;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; ar_ready = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (s_r_ready) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rdr_reached", 32'(seen), 32'd1);
        chk("rdr_error_before_rst", 32'(s_error), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_r_ready", 32'(s_r_ready), 32'd0);
        chk("async_rst_error", 32'(s_error), 32'd0);
        chk("async_rst_valids", 32'({s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_done}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_r_ready", 32'(s_r_ready), 32'd0);
        run_seq(vecs[0], 1'b0, n_ar, fin);
        chk("replay_reached_done", 32'(fin), 32'd1);
        chk("replay_retval", 32'(s_retval), 32'h2A);
        chk("replay_error", 32'(s_error), 32'd0);
        chk("replay_ar_count", 32'(n_ar), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
